// File: rtl/fabric_rr_arbiter.sv
// fabric_rr_arbiter: masked round-robin merge of NUM_INPUTS valid/ready streams into one registered output.
// Optional FABRIC_RR_ARBITER_STATS_EN adds a saturating stall_count output.
module fabric_rr_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 0,
    localparam int PW        = DATA_WIDTH + TAG_WIDTH,
    localparam int ID_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_INPUTS-1:0]    in_valid,
    output logic [NUM_INPUTS-1:0]    in_ready,
    input  logic [NUM_INPUTS*PW-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PW-1:0]            out_data,
    output logic [ID_WIDTH-1:0]      out_id,
    input  logic [NUM_INPUTS-1:0]    cfg_data
`ifdef FABRIC_RR_ARBITER_STATS_EN
    ,
    output logic [31:0]              stall_count
`endif
);
    logic                  r_valid;
    logic [PW-1:0]         r_data;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [NUM_INPUTS-1:0] w_elig;
    logic                  w_load;
    logic                  w_found;
    logic                  w_fire;
    logic [ID_WIDTH-1:0]   w_win;
    logic [ID_WIDTH-1:0]   w_next_ptr;

    assign w_elig = in_valid & cfg_data;
    assign w_load = !r_valid || out_ready;

    // Scan from highest offset down so the offset closest to r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (w_elig[(int'(r_ptr) + k) % NUM_INPUTS]) begin
                w_found = 1'b1;
                w_win   = ID_WIDTH'((int'(r_ptr) + k) % NUM_INPUTS);
            end
        end
    end

    assign w_fire     = !rst && w_found && w_load;
    assign w_next_ptr = (int'(w_win) == NUM_INPUTS - 1) ? '0 : w_win + 1'b1;
    assign in_ready   = w_fire ? (NUM_INPUTS'(1) << w_win) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_data  <= in_data[int'(w_win)*PW +: PW];
            r_id    <= w_win;
            r_ptr   <= w_next_ptr;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_id    = r_id;

`ifdef FABRIC_RR_ARBITER_STATS_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall <= '0;
        else if (r_valid && !out_ready && r_stall != 32'hFFFF_FFFF)
            r_stall <= r_stall + 32'd1;
    end

    assign stall_count = r_stall;
`endif
endmodule

// File: tb/tb_fabric_rr_arbiter.sv
// tb_fabric_rr_arbiter: reference-model and scoreboard bench for fabric_rr_arbiter (NUM_INPUTS=4).
module tb_fabric_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int ITEMS = 200;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;
    logic [N-1:0]    cfg_data = '1;
`ifdef FABRIC_RR_ARBITER_STATS_EN
    logic [31:0]     stall_count;
`endif

    logic [DW-1:0] d [N];
    always_comb for (int i = 0; i < N; i++) in_data[i*DW +: DW] = d[i];

    fabric_rr_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .TAG_WIDTH(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
        .cfg_data(cfg_data)
`ifdef FABRIC_RR_ARBITER_STATS_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic          m_ov = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [1:0]    m_id = '0;
    int            m_ptr = 0;
    logic          m_fire;
    int            m_win;
    logic [31:0]   m_stall = '0;
    logic [33:0]   exp_q [$];
    int            rx [N];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        logic         load, found;
        logic [N-1:0] elig, exp_rdy;
        logic [33:0]  e;
        @(negedge clk);
        load  = !m_ov || out_ready;
        elig  = in_valid & cfg_data;
        found = 1'b0;
        m_win = 0;
        for (int k = 0; k < N && !found; k++)
            if (elig[(m_ptr + k) % N]) begin
                found = 1'b1;
                m_win = (m_ptr + k) % N;
            end
        m_fire  = !rst && found && load;
        exp_rdy = m_fire ? N'(1) << m_win : '0;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            check("out_id", 64'(out_id), 64'(m_id));
            check("out_data", 64'(out_data), 64'(m_data));
        end
        if (!rst && out_valid && out_ready) begin
            check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_item", 64'({out_id, out_data}), 64'(e));
                rx[e[33:32]]++;
            end
        end
        if (rst) begin
            m_ov = 1'b0; m_data = '0; m_id = '0; m_ptr = 0; m_stall = '0;
            exp_q.delete();
        end else begin
            if (m_ov && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (m_fire) begin
                m_ov = 1'b1; m_data = d[m_win]; m_id = 2'(m_win); m_ptr = (m_win + 1) % N;
                exp_q.push_back({2'(m_win), d[m_win]});
            end else if (out_ready) m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int held;
        int seq [N];
        int cyc;
        logic done;
        for (int i = 0; i < N; i++) begin d[i] = 32'h100 * (i + 1); rx[i] = 0; seq[i] = 0; end
        // Reset
        repeat (3) step();
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_id", 64'(out_id), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        step();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        // Single item from input 2
        out_ready = 1'b1;
        d[2] = 32'h42;
        in_valid = 4'b0100;
        step();
        in_valid = '0;
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_data", 64'(out_data), 64'h42);
        check("single_id", 64'(out_id), 64'd2);
        step();
        check("single_drain", 64'(out_valid), 64'd0);
        // Fairness from a fresh pointer
        rst = 1'b1; step(); rst = 1'b0;
        in_valid = '1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("fair_id", 64'(out_id), 64'(k % N));
        end
        // Backpressure
        out_ready = 1'b0;
        held = int'(m_id);
        repeat (5) begin
            step();
            check("bp_id", 64'(out_id), 64'(held));
            check("bp_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_resume_id", 64'(out_id), 64'((held + 1) % N));
        // Enable mask
        cfg_data = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            step();
            check("mask_id", 64'(out_id), (k % 2) ? 64'd3 : 64'd1);
        end
        // Reset while an item is held
        out_ready = 1'b0;
        step();
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        in_valid = '0;
        cfg_data = '1;
        for (int i = 0; i < N; i++) rx[i] = 0;
        // Random traffic with per-input sequence numbers
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 20000) begin
            for (int i = 0; i < N; i++) begin
                if (seq[i] < ITEMS && !in_valid[i]) in_valid[i] = 1'($urandom % 2);
                d[i] = {8'(i), 24'(seq[i])};
            end
            out_ready = ($urandom % 10) < 7;
            cfg_data = ($urandom % 4 == 0) ? 4'($urandom) : 4'hF;
            step();
            if (m_fire) begin
                seq[m_win]++;
                in_valid[m_win] = 1'b0;
            end
            done = 1'b1;
            for (int i = 0; i < N; i++) if (seq[i] < ITEMS) done = 1'b0;
            cyc++;
        end
        check("rand_timeout", 64'(done), 64'd1);
        in_valid = '0;
        out_ready = 1'b1;
        repeat (3) step();
        check("rand_sb_empty", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < N; i++) check("rand_count", 64'(rx[i]), 64'(ITEMS));
`ifdef FABRIC_RR_ARBITER_STATS_EN
        check("stall_count", 64'(stall_count), 64'(m_stall));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
